// File: rtl/mem_arbiter6502.sv
// Single-port RAM arbiter for system6502: sequences the 6502 reset release, then
// shares memory between the CPU (priority) and a DMA requester with bounded wait.
module mem_arbiter6502 #(
   parameter int RESET_CYCLES = 10,
   parameter int MAX_STREAK   = 4,
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  cpu_reset,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_rdy,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dma_req,
   input  logic                  dma_halt,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic                  dma_we,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_ack,
   output logic                  dma_rvalid,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int HOLD_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
   localparam int STREAK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

   localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t              state, state_next;
   logic [HOLD_W-1:0]   hold_cnt, hold_next;
   logic [STREAK_W-1:0] streak, streak_next;
   logic                dma_turn;

   // Saturating increment keeps the streak inside 0..MAX_STREAK.
   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
      if (s == STREAK_MAX) begin
         return s;
      end
      return s + 1'b1;
   endfunction

   assign dma_turn = dma_req && (streak == STREAK_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HOLD;
         hold_cnt   <= '0;
         streak     <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         state      <= state_next;
         hold_cnt   <= hold_next;
         streak     <= streak_next;
         dma_rvalid <= dma_ack & ~dma_we;
      end
   end

   always_comb begin
      state_next  = state;
      hold_next   = hold_cnt;
      streak_next = streak;
      case (state)
         HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_next = RUN;
               hold_next  = '0;
            end else begin
               hold_next = hold_cnt + 1'b1;
            end
         end
         RUN: begin
            // A pending request lengthens the CPU streak; the DMA slot resets it.
            if (dma_turn || !dma_req) begin
               streak_next = '0;
            end else begin
               streak_next = streak_inc(streak);
            end
            if (dma_halt) begin
               state_next = HALT;
            end
         end
         HALT: begin
            streak_next = '0;
            if (!dma_halt) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next  = HOLD;
            hold_next   = '0;
            streak_next = '0;
         end
      endcase
   end

   always_comb begin
      cpu_reset = 1'b0;
      cpu_rdy   = 1'b0;
      dma_ack   = 1'b0;
      mem_addr  = cpu_addr;
      mem_we    = 1'b0;
      mem_wdata = cpu_wdata;
      case (state)
         HOLD: begin
            cpu_reset = 1'b1;
         end
         RUN: begin
            if (dma_turn) begin
               dma_ack   = 1'b1;
               mem_addr  = dma_addr;
               mem_we    = dma_we;
               mem_wdata = dma_wdata;
            end else begin
               cpu_rdy = 1'b1;
               mem_we  = cpu_we;
            end
         end
         HALT: begin
            if (dma_req) begin
               dma_ack   = 1'b1;
               mem_addr  = dma_addr;
               mem_we    = dma_we;
               mem_wdata = dma_wdata;
            end
         end
         default: begin
            cpu_reset = 1'b1;
         end
      endcase
   end

   // Synchronous RAM: read data belongs to the address granted one clock earlier.
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter6502.sv
// Directed bench for mem_arbiter6502: reset release, fairness, DMA write/read,
// halt mode and reset during HALT, against a behavioural synchronous RAM.
module tb_mem_arbiter6502;

   logic        clk;
   logic        reset;
   logic        cpu_reset;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic        cpu_rdy;
   logic [7:0]  cpu_rdata;
   logic        dma_req;
   logic        dma_halt;
   logic [15:0] dma_addr;
   logic        dma_we;
   logic [7:0]  dma_wdata;
   logic        dma_ack;
   logic        dma_rvalid;
   logic [7:0]  dma_rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int errors = 0;
   int checks = 0;

   logic [7:0] ram [0:65535];

   mem_arbiter6502 #(
      .RESET_CYCLES(10),
      .MAX_STREAK  (4),
      .ADDR_WIDTH  (16),
      .DATA_WIDTH  (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_reset (cpu_reset),
      .cpu_addr  (cpu_addr),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_rdy   (cpu_rdy),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_halt  (dma_halt),
      .dma_addr  (dma_addr),
      .dma_we    (dma_we),
      .dma_wdata (dma_wdata),
      .dma_ack   (dma_ack),
      .dma_rvalid(dma_rvalid),
      .dma_rdata (dma_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
   end

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns sampled at the negedge of the ack clock (not yet advanced); lat=-1 on timeout.
   task automatic wait_ack(output int lat);
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         if (dma_ack === 1'b1) return;
         step();
         lat++;
      end
      lat = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  n;
      logic prev_dma;
      logic exp_dma;
      logic [15:0] addr_tab [4];
      logic        we_tab   [4];
      addr_tab = '{16'h1234, 16'h0010, 16'hFFFF, 16'h0400};
      we_tab   = '{1'b1, 1'b0, 1'b1, 1'b0};

      reset     = 1'b1;
      cpu_addr  = 16'h0100;
      cpu_we    = 1'b0;
      cpu_wdata = 8'h00;
      dma_req   = 1'b1;
      dma_halt  = 1'b0;
      dma_addr  = 16'h0300;
      dma_we    = 1'b0;
      dma_wdata = 8'h00;

      // Reset values, three clocks of reset with a DMA request already pending
      step();
      check("rst_cpu_reset", cpu_reset, 1'b1);
      check("rst_cpu_rdy", cpu_rdy, 1'b0);
      check("rst_dma_ack", dma_ack, 1'b0);
      check("rst_dma_rvalid", dma_rvalid, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      step();
      step();
      reset = 1'b0;

      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check("hold_cpu_reset", cpu_reset, 1'b1);
         check("hold_cpu_rdy", cpu_rdy, 1'b0);
         check("hold_dma_ack", dma_ack, 1'b0);
         step();
      end

      // Clock 11 onward: 4 CPU grants then 1 DMA grant, repeating
      prev_dma = 1'b0;
      for (int k = 0; k < 15; k++) begin
         exp_dma = ((k % 5) == 4);
         @(negedge clk);
         check("run_cpu_reset", cpu_reset, 1'b0);
         check("fair_cpu_rdy", cpu_rdy, !exp_dma);
         check("fair_dma_ack", dma_ack, exp_dma);
         check("fair_dma_rvalid", dma_rvalid, prev_dma);
         if (exp_dma) check("fair_mem_addr", mem_addr, 16'h0300);
         prev_dma = exp_dma;
         step();
      end
      dma_req = 1'b0;

      // No DMA traffic: CPU owns every clock
      for (int i = 0; i < 4; i++) begin
         cpu_addr  = addr_tab[i];
         cpu_we    = we_tab[i];
         cpu_wdata = 8'h30 + 8'(i);
         @(negedge clk);
         check("nodma_cpu_rdy", cpu_rdy, 1'b1);
         check("nodma_dma_ack", dma_ack, 1'b0);
         check("nodma_mem_addr", mem_addr, addr_tab[i]);
         check("nodma_mem_we", mem_we, we_tab[i]);
         step();
      end
      cpu_we   = 1'b0;
      cpu_addr = 16'h0100;

      // DMA write 0xA5 to 0x0200, then read it back
      dma_addr  = 16'h0200;
      dma_wdata = 8'hA5;
      dma_we    = 1'b1;
      dma_req   = 1'b1;
      wait_ack(lat);
      check("dwr_latency", lat, 32'd4);
      check("dwr_mem_we", mem_we, 1'b1);
      check("dwr_mem_addr", mem_addr, 16'h0200);
      check("dwr_mem_wdata", mem_wdata, 8'hA5);
      check("dwr_cpu_rdy", cpu_rdy, 1'b0);
      step();
      dma_we = 1'b0;
      @(negedge clk);
      check("dwr_no_rvalid", dma_rvalid, 1'b0);
      check("dwr_streak_clr", cpu_rdy, 1'b1);
      step();
      wait_ack(lat);
      check("drd_latency", lat, 32'd3);
      check("drd_mem_we", mem_we, 1'b0);
      check("drd_mem_addr", mem_addr, 16'h0200);
      step();
      dma_req = 1'b0;
      @(negedge clk);
      check("drd_rvalid", dma_rvalid, 1'b1);
      check("drd_rdata", dma_rdata, 8'hA5);
      check("drd_cpu_rdata", cpu_rdata, 8'hA5);
      step();

      // Halt mode: the request clock is still arbitrated as RUN
      dma_req  = 1'b1;
      dma_halt = 1'b1;
      @(negedge clk);
      check("halt_entry_cpu_rdy", cpu_rdy, 1'b1);
      check("halt_entry_dma_ack", dma_ack, 1'b0);
      step();
      for (int j = 1; j <= 8; j++) begin
         if (j == 8) dma_halt = 1'b0;
         @(negedge clk);
         check("halt_dma_ack", dma_ack, 1'b1);
         check("halt_cpu_rdy", cpu_rdy, 1'b0);
         if (j >= 2) begin
            check("halt_rvalid", dma_rvalid, 1'b1);
            check("halt_rdata", dma_rdata, 8'hA5);
         end
         step();
      end
      for (int r = 0; r < 5; r++) begin
         exp_dma = (r == 4);
         @(negedge clk);
         check("post_halt_cpu_rdy", cpu_rdy, !exp_dma);
         check("post_halt_dma_ack", dma_ack, exp_dma);
         step();
      end

      // HALT with no request must keep the RAM write disabled
      dma_req   = 1'b0;
      dma_we    = 1'b1;
      dma_halt  = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 16'h0500;
      cpu_wdata = 8'h5A;
      @(negedge clk);
      check("idle_run_cpu_rdy", cpu_rdy, 1'b1);
      check("idle_run_mem_we", mem_we, 1'b1);
      step();
      @(negedge clk);
      check("idle_halt_mem_we", mem_we, 1'b0);
      check("idle_halt_cpu_rdy", cpu_rdy, 1'b0);
      check("idle_halt_dma_ack", dma_ack, 1'b0);
      step();

      // Reset arriving during a HALT-mode DMA read
      dma_req = 1'b1;
      dma_we  = 1'b0;
      cpu_we  = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      check("rsthalt_ack", dma_ack, 1'b1);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rsthalt_cpu_reset", cpu_reset, 1'b1);
      check("rsthalt_rvalid", dma_rvalid, 1'b0);
      check("rsthalt_dma_ack", dma_ack, 1'b0);
      check("rsthalt_cpu_rdy", cpu_rdy, 1'b0);
      n = 1;
      step();
      @(negedge clk);
      while (cpu_reset === 1'b1 && n < 30) begin
         n++;
         step();
         @(negedge clk);
      end
      check("rsthalt_hold_len", n, 32'd10);
      check("rsthalt_first_rdy", cpu_rdy, 1'b1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter6502.md
# mem_arbiter6502

Shares the single-port system RAM of system6502 between the 6502 core and a DMA requester (debug loader / display scanner), and sequences the CPU's reset release. After reset it holds the CPU in reset for a programmable number of clocks, then grants memory cycle by cycle with CPU priority and a bounded DMA wait. A DMA halt mode lets the DMA requester own memory exclusively for block transfers.

## Interface
- RESET_CYCLES, 10: clocks `cpu_reset` stays high after `reset` deasserts (≥1).
- MAX_STREAK, 4: max consecutive CPU grants while `dma_req` is pending (≥1).
- ADDR_WIDTH, 16: address width.
- DATA_WIDTH, 8: data width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_reset  out  1  reset to 6502 core.
- cpu_addr  in  ADDR_WIDTH  CPU address; held by core while `cpu_rdy`=0.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdy  out  1  CPU cycle granted this clock.
- cpu_rdata  out  DATA_WIDTH  equals `mem_rdata`.
- dma_req  in  1  DMA access request; hold with address/data until `dma_ack`.
- dma_halt  in  1  request exclusive DMA ownership.
- dma_addr  in  ADDR_WIDTH  DMA address.
- dma_we  in  1  DMA write strobe.
- dma_wdata  in  DATA_WIDTH  DMA write data.
- dma_ack  out  1  DMA access granted this clock.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  DATA_WIDTH  equals `mem_rdata`.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, one clock after address (synchronous RAM).

## Operation
- FSM states: HOLD, RUN, HALT. Registers: state, hold counter, streak counter (0..MAX_STREAK), `dma_rvalid`.
- HOLD: `cpu_reset`=1, `cpu_rdy`=0, `dma_ack`=0, `mem_we`=0. Counter counts from 0; after RESET_CYCLES clocks in HOLD go to RUN. `dma_req` is ignored (stays pending).
- RUN (`cpu_reset`=0), grant decided combinationally each clock:
  - grant DMA if `dma_req`=1 and streak==MAX_STREAK; else grant CPU.
  - CPU grant: `cpu_rdy`=1, `mem_*` from `cpu_*`. If `dma_req`=1, streak increments; if `dma_req`=0, streak clears.
  - DMA grant: `dma_ack`=1, `cpu_rdy`=0, `mem_*` from `dma_*`, streak clears.
  - Consequence: with `dma_req` held, DMA receives 1 of every MAX_STREAK+1 clocks.
- RUN -> HALT when `dma_halt`=1 (sampled at the clock edge; the transition clock itself is arbitrated as RUN).
- HALT: `cpu_rdy`=0 every clock; DMA granted every clock `dma_req`=1; `mem_we`=0 when `dma_req`=0. HALT -> RUN when `dma_halt`=0; streak clears on entry to RUN.
- `dma_rvalid` registered: next clock = `dma_ack & ~dma_we`.
- `mem_addr`/`mem_wdata` default to CPU values when nothing granted.
- `reset` in any state, including mid-HALT or mid-DMA: state->HOLD, counters->0, `dma_rvalid`->0; a DMA read granted in the reset clock gets no `dma_rvalid`.

## Timing
- Reset values: `cpu_reset`=1, `cpu_rdy`=0, `dma_ack`=0, `dma_rvalid`=0, `mem_we`=0.
- `cpu_reset` falls RESET_CYCLES clocks after the first clock with `reset` low; `cpu_rdy` can assert that same clock.
- Grant-to-write: same clock (`mem_we` combinational with grant).
- Read latency: `cpu_rdata`/`dma_rdata` valid the clock after grant; `dma_rvalid` marks it.
- `dma_req`/`dma_halt` to first grant in RUN: ≤ MAX_STREAK+1 clocks; in HALT: 0 clocks.
- No combinational path from `mem_rdata` to any control output.

## Test plan
- Reset release: `reset` high 3 clocks then low -> `cpu_reset` high exactly 10 further clocks, `cpu_rdy`=1 on clock 11, `dma_ack` never high during HOLD.
- Fairness: `dma_req` held continuously in RUN, MAX_STREAK=4 -> repeating pattern 4 `cpu_rdy` then 1 `dma_ack`; streak clears on the DMA clock.
- DMA write/read: DMA writes 0xA5 to 0x0200, then reads 0x0200 -> `mem_we`=1 with `mem_addr`=0x0200 on ack clock; `dma_rvalid`=1 with `dma_rdata`=0xA5 next clock after read ack.
- Halt mode: assert `dma_halt` with `dma_req` held 8 clocks -> 8 consecutive `dma_ack`, `cpu_rdy`=0 throughout; drop `dma_halt` -> `cpu_rdy`=1 next clock, streak restarts at 0.
- No DMA: `dma_req`=0 -> `cpu_rdy`=1 every RUN clock, `mem_addr`=`cpu_addr`, `mem_we`=`cpu_we`.
- Reset mid-HALT: `reset` during DMA read ack -> next clock state HOLD, `cpu_reset`=1, `dma_rvalid`=0, `dma_ack`=0.
